counter_bank: RTL

- Parametrised successor of the single-channel control-coded register used across the bomb controller datapath.
- Holds CHANNELS independent DATA_WIDTH registers. Each channel has its own control code: NONE/CLR/LOAD/INCR/DECR.
- Adds a programmable step, wrap/saturate/reload overflow modes, zero and max status flags, and a registered one-cycle event pulse per channel.
- Serves countdown timers, attempt counters and code-digit registers from a single instance.

---
 rtl/counter_bank_if.sv | 31 +++
 rtl/counter_bank.sv | 124 ++++++++++++
 2 files changed

// File: rtl/counter_bank_if.sv
// Bus bundle for counter_bank: per-channel control codes and load values in,
// register values, status flags and event pulses out.
// "event" is a reserved word in SystemVerilog, so the event output is named event_pulse.
interface counter_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int CTRL_WIDTH = 3
);

  logic [CHANNELS*CTRL_WIDTH-1:0] ctrl;
  logic [CHANNELS*DATA_WIDTH-1:0] data_input;
  logic [DATA_WIDTH-1:0]          step;
  logic [1:0]                     mode;
  logic [CHANNELS*DATA_WIDTH-1:0] data_output;
  logic [CHANNELS-1:0]            zero;
  logic [CHANNELS-1:0]            max;
  logic [CHANNELS-1:0]            event_pulse;

  // The controller drives codes and operands and observes the bank.
  modport master (
    output ctrl, data_input, step, mode,
    input  data_output, zero, max, event_pulse
  );

  // The bank consumes codes and operands and reports its state.
  modport slave (
    input  ctrl, data_input, step, mode,
    output data_output, zero, max, event_pulse
  );

endinterface

// File: rtl/counter_bank.sv
// Bank of independent control-coded registers.
// Each channel can hold, clear, load, or step up/down by a shared amount.
// Overflow handling is selectable as wrap, saturate or reload.
// A one-cycle event pulse marks each boundary crossing.
module counter_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int CTRL_WIDTH = 3
) (
  input logic           clk,
  input logic           rst,
  counter_bank_if.slave bus
);

  localparam logic [CTRL_WIDTH-1:0] CODE_NONE = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CODE_CLR  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CODE_LOAD = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] CODE_INCR = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] CODE_DECR = CTRL_WIDTH'(4);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  // Mode 3 is not a distinct behaviour; it falls back to wrapping.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SATURATE = 2'd1,
    MODE_RELOAD   = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } mode_e;

  mode_e mode_sel;

  logic [DATA_WIDTH-1:0] value_q    [CHANNELS];
  logic [CHANNELS-1:0]   event_q;

  assign mode_sel = mode_e'(bus.mode);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel

    logic [CTRL_WIDTH-1:0] code;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic                  overflow;
    logic                  underflow;
    logic [DATA_WIDTH-1:0] next_value;
    logic                  next_event;

    assign code       = bus.ctrl[ch*CTRL_WIDTH +: CTRL_WIDTH];
    assign load_value = bus.data_input[ch*DATA_WIDTH +: DATA_WIDTH];

    // The extra top bit of the widened sum/difference is the carry/borrow.
    // A zero step can therefore never signal a crossing.
    assign sum       = {1'b0, value_q[ch]} + {1'b0, bus.step};
    assign diff      = {1'b0, value_q[ch]} - {1'b0, bus.step};
    assign overflow  = sum[DATA_WIDTH];
    assign underflow = diff[DATA_WIDTH];

    // Decode the channel's control code into its next value and event flag.
    always_comb begin
      next_value = value_q[ch];
      next_event = 1'b0;
      case (code)
        CODE_NONE: next_value = value_q[ch];
        CODE_CLR:  next_value = '0;
        CODE_LOAD: next_value = load_value;
        CODE_INCR: begin
          if (overflow) begin
            next_event = 1'b1;
            case (mode_sel)
              MODE_SATURATE: next_value = ALL_ONES;
              MODE_RELOAD:   next_value = '0;
              default:       next_value = sum[DATA_WIDTH-1:0];
            endcase
          end else begin
            next_value = sum[DATA_WIDTH-1:0];
          end
        end
        CODE_DECR: begin
          if (underflow) begin
            next_event = 1'b1;
            case (mode_sel)
              MODE_SATURATE: next_value = '0;
              MODE_RELOAD:   next_value = load_value;
              default:       next_value = diff[DATA_WIDTH-1:0];
            endcase
          end else begin
            next_value = diff[DATA_WIDTH-1:0];
          end
        end
        default: next_value = value_q[ch];
      endcase
    end

    // Register the channel value and its event pulse.
    // Both clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        value_q[ch] <= '0;
        event_q[ch] <= 1'b0;
      end else begin
        value_q[ch] <= next_value;
        event_q[ch] <= next_event;
      end
    end

  end

  // Pack register values onto the bus.
  // The status flags come straight off the registers with no extra latency.
  always_comb begin
    bus.data_output = '0;
    bus.zero        = '0;
    bus.max         = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      bus.data_output[ch*DATA_WIDTH +: DATA_WIDTH] = value_q[ch];
      bus.zero[ch] = (value_q[ch] == '0);
      bus.max[ch]  = (value_q[ch] == ALL_ONES);
    end
  end

  assign bus.event_pulse = event_q;

endmodule
